// File: rtl/sd_cmd_serializer_pkg.sv
// Shared definitions for the SD CMD-line serializer: state encodings, frame sizes, CRC7 step.
package sd_cmd_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEND = 3'd1,
      ST_CRC  = 3'd2,
      ST_ENDB = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [6:0] CRC7_POLY = 7'h09;
   localparam int         FRAME_R1  = 48;
   localparam int         FRAME_R2  = 136;
   // CRC7 plus end bit occupy the tail of every CRC-protected frame
   localparam int         CRC_TAIL  = 8;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (CRC7_POLY & {7{fb}});
   endfunction

endpackage

// File: rtl/sd_cmd_serializer_crc7.sv
// Serial CRC7 engine (x^7+x^3+1); clear and shift may coincide, clear applies first.
module sd_crc7
   import sd_cmd_serializer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       shift_en,
   input  logic       din,
   output logic [6:0] crc
);

   logic [6:0] base;

   always_comb base = clear ? 7'd0 : crc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           crc <= '0;
      else if (shift_en) crc <= crc7_step(base, din);
      else               crc <= base;
   end

endmodule

// File: rtl/sd_cmd_serializer.sv
// CMD-line frame serializer with strobe/complete handshake and abort.
// Define SD_CMD_CRC7_EN to generate CRC7 and the end bit in the last 8 frame bits.
module sd_cmd_serializer
   import sd_cmd_serializer_pkg::*;
#(
   parameter int MAX_FRAME = 136,
   parameter int CNT_W     = 8
) (
   input  logic                 sd_clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 load_send,
   input  logic [CNT_W-1:0]     framesize,
   input  logic                 crc_skip_hdr,
   input  logic [MAX_FRAME-1:0] parallel,
   output logic                 serial,
   output logic                 cmd_oe,
   output logic                 busy,
   output logic                 complete,
   output logic                 error
);

   state_t               state;
   logic [MAX_FRAME-1:0] shreg;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     limit;
   logic                 req;
   logic                 legal;

   assign req = enable & load_send;

`ifdef SD_CMD_CRC7_EN
   localparam logic [CNT_W-1:0] MIN_FRAME = CNT_W'(CRC_TAIL + 1);

   logic       skip_q;
   logic [2:0] crc_idx;
   logic       crc_clr;
   logic       crc_sh;
   logic       crc_din;
   logic [6:0] crc;

   // The CRC absorbs each data bit on the edge that puts it on the line.
   always_comb begin
      crc_clr = 1'b0;
      crc_sh  = 1'b0;
      crc_din = 1'b0;
      if (state == ST_IDLE && req && legal) begin
         crc_clr = 1'b1;
         crc_sh  = ~crc_skip_hdr;
         crc_din = parallel[MAX_FRAME-1];
      end else if (state == ST_SEND && enable && cnt != limit) begin
         crc_sh  = ~(skip_q && cnt < CNT_W'(CRC_TAIL));
         crc_din = shreg[MAX_FRAME-1];
      end
   end

   sd_crc7 u_crc (
      .clk      (sd_clock),
      .rst      (reset),
      .clear    (crc_clr),
      .shift_en (crc_sh),
      .din      (crc_din),
      .crc      (crc)
   );
`else
   localparam logic [CNT_W-1:0] MIN_FRAME = CNT_W'(1);

   logic unused_skip;
   assign unused_skip = crc_skip_hdr;
`endif

   assign legal = (framesize >= MIN_FRAME) && (framesize <= CNT_W'(MAX_FRAME));

   // State names the phase currently on the line; cnt counts bits already driven.
   always_ff @(posedge sd_clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         cnt      <= '0;
         limit    <= '0;
         serial   <= 1'b1;
         cmd_oe   <= 1'b0;
         busy     <= 1'b0;
         complete <= 1'b0;
         error    <= 1'b0;
`ifdef SD_CMD_CRC7_EN
         skip_q   <= 1'b0;
         crc_idx  <= '0;
`endif
      end else begin
         error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  if (legal) begin
                     state  <= ST_SEND;
                     serial <= parallel[MAX_FRAME-1];
                     shreg  <= {parallel[MAX_FRAME-2:0], 1'b0};
                     cnt    <= CNT_W'(1);
                     cmd_oe <= 1'b1;
                     busy   <= 1'b1;
`ifdef SD_CMD_CRC7_EN
                     limit  <= framesize - CNT_W'(CRC_TAIL);
                     skip_q <= crc_skip_hdr;
`else
                     limit  <= framesize;
`endif
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (!enable) begin
                  state  <= ST_IDLE;
                  serial <= 1'b1;
                  cmd_oe <= 1'b0;
                  busy   <= 1'b0;
               end else if (cnt == limit) begin
`ifdef SD_CMD_CRC7_EN
                  state   <= ST_CRC;
                  serial  <= crc[6];
                  crc_idx <= 3'd6;
`else
                  state    <= ST_DONE;
                  serial   <= 1'b1;
                  cmd_oe   <= 1'b0;
                  busy     <= 1'b0;
                  complete <= 1'b1;
`endif
               end else begin
                  serial <= shreg[MAX_FRAME-1];
                  shreg  <= {shreg[MAX_FRAME-2:0], 1'b0};
                  cnt    <= cnt + CNT_W'(1);
               end
            end
`ifdef SD_CMD_CRC7_EN
            ST_CRC: begin
               if (!enable) begin
                  state  <= ST_IDLE;
                  serial <= 1'b1;
                  cmd_oe <= 1'b0;
                  busy   <= 1'b0;
               end else if (crc_idx == 3'd0) begin
                  state  <= ST_ENDB;
                  serial <= 1'b1;
               end else begin
                  serial  <= crc[crc_idx - 3'd1];
                  crc_idx <= crc_idx - 3'd1;
               end
            end
            ST_ENDB: begin
               state  <= enable ? ST_DONE : ST_IDLE;
               serial <= 1'b1;
               cmd_oe <= 1'b0;
               busy   <= 1'b0;
               complete <= enable;
            end
`endif
            ST_DONE: begin
               if (!load_send) begin
                  state    <= ST_IDLE;
                  complete <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               serial   <= 1'b1;
               cmd_oe   <= 1'b0;
               busy     <= 1'b0;
               complete <= 1'b0;
            end
         endcase
      end
   end

endmodule
